// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared types and constants for the CRC16 frame controller:
//   - state_t      : controller FSM state encoding
//   - POLY_DEF     : default generator polynomial (CRC-16/CCITT, MSB-first)
//   - INIT_DEF     : default CRC preset value
//   - BIT_IDX_W    : bit index width (covers 8 data bits and 16 CRC bits)
//   - crc16_step() : one serial LFSR step, MSB-first, non-reflected
// -----------------------------------------------------------------------------
package crc16_pkg;

  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] INIT_DEF  = 16'h0000;
  localparam int          BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_WAIT = 3'd2,
    S_CRC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Feedback is the outgoing MSB XOR the incoming bit; when set the
  // polynomial is folded into the shifted register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// -----------------------------------------------------------------------------
// crc16_serial
// Bit-serial CRC16 LFSR. Preset to INIT on reset or clr_i, advances one bit
// per cycle while en_i is high, holds otherwise. clr_i has priority.
// Ports:
//   clk_i    in   clock, rising edge
//   rstn_i   in   asynchronous active-low reset
//   clr_i    in   load INIT
//   en_i     in   shift data_i into the CRC
//   data_i   in   serial data bit, MSB of each byte first
//   crc16_o  out  current CRC register
// -----------------------------------------------------------------------------
module crc16_serial
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = POLY_DEF,
  parameter logic [15:0] INIT = INIT_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        data_i,
  output logic [15:0] crc16_o
);

  logic [15:0] r_crc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_crc <= INIT;
    end else if (clr_i) begin
      r_crc <= INIT;
    end else if (en_i) begin
      r_crc <= crc16_step(r_crc, data_i, POLY);
    end
  end

  assign crc16_o = r_crc;

endmodule

// File: rtl/crc16_frame_ctrl.sv
// -----------------------------------------------------------------------------
// crc16_frame_ctrl
// Accepts a byte stream framed by s_last_i, serialises it MSB first on bit_o
// while computing CRC16 over the data bits, then appends the 16 CRC bits.
// crc16_o is updated at done_o and held until the next frame's done_o.
//
// Optional feature macro: CRC16_CHECK_EN
//   Adds check_i / crc_ok_o. A frame started with check_i=1 is treated as
//   data followed by its received CRC: no CRC bits are emitted, DONE follows
//   the last data bit, and crc_ok_o reports a zero remainder.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rstn_i       in   asynchronous active-low reset
//   s_data_i     in   frame byte
//   s_valid_i    in   byte valid
//   s_last_i     in   byte is last of frame
//   s_ready_o    out  byte accepted when s_valid_i is also high
//   bit_o        out  serial bit, MSB first (0 when bit_valid_o is low)
//   bit_valid_o  out  bit_o carries a frame bit
//   busy_o       out  frame in progress
//   done_o       out  one-cycle frame-end pulse
//   crc16_o      out  CRC of the last completed frame
//   check_i      in   (CRC16_CHECK_EN) check mode, sampled on first byte
//   crc_ok_o     out  (CRC16_CHECK_EN) zero remainder, valid with done_o
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no frame; ready for the first byte
// DATA   | shifting a data byte out, CRC advancing each bit
// WAIT   | between bytes with no byte available; CRC held
// CRC    | shifting the 16 latched CRC bits out
// DONE   | single-cycle frame-end pulse, crc16_o updated on entry
// -----------------------------------------------------------------------------
module crc16_frame_ctrl
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = POLY_DEF,
  parameter logic [15:0] INIT = INIT_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic        bit_o,
  output logic        bit_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] crc16_o
`ifdef CRC16_CHECK_EN
  ,
  input  logic        check_i,
  output logic        crc_ok_o
`endif
);

  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [BIT_IDX_W-1:0]   r_idx;
  logic                   r_last;
  logic [15:0]            r_crc_src;
  logic [15:0]            r_crc_out;
`ifdef CRC16_CHECK_EN
  logic                   r_check;
  logic                   r_crc_ok;
`endif

  logic                   w_xfer;
  logic                   w_clr;
  logic                   w_en;
  logic [15:0]            w_crc;
  logic [15:0]            w_crc_next;
  logic                   w_bit;

  assign s_ready_o = (r_state == S_IDLE) || (r_state == S_WAIT) ||
                     ((r_state == S_DATA) && (r_idx == 4'd7) && !r_last);
  assign w_xfer    = s_valid_i && s_ready_o;
  assign w_clr     = (r_state == S_IDLE) && w_xfer;
  assign w_en      = (r_state == S_DATA);

  crc16_serial #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_crc (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (w_clr),
    .en_i    (w_en),
    .data_i  (r_shift[7]),
    .crc16_o (w_crc)
  );

  // The LFSR absorbs the last data bit on the same edge that leaves DATA,
  // so the final CRC is taken from its next-state value.
  assign w_crc_next = crc16_step(w_crc, r_shift[7], POLY);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_crc_src <= 16'h0000;
      r_crc_out <= 16'h0000;
`ifdef CRC16_CHECK_EN
      r_check   <= 1'b0;
      r_crc_ok  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_shift <= s_data_i;
            r_last  <= s_last_i;
            r_idx   <= '0;
            r_state <= S_DATA;
`ifdef CRC16_CHECK_EN
            r_check <= check_i;
`endif
          end
        end

        S_DATA: begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_idx   <= r_idx + 4'd1;
          if (r_idx == 4'd7) begin
            r_idx <= '0;
            if (r_last) begin
`ifdef CRC16_CHECK_EN
              if (r_check) begin
                r_crc_out <= w_crc_next;
                r_crc_ok  <= (w_crc_next == 16'h0000);
                r_state   <= S_DONE;
              end else begin
                r_crc_src <= w_crc_next;
                r_state   <= S_CRC;
              end
`else
              r_crc_src <= w_crc_next;
              r_state   <= S_CRC;
`endif
            end else if (w_xfer) begin
              r_shift <= s_data_i;
              r_last  <= s_last_i;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (w_xfer) begin
            r_shift <= s_data_i;
            r_last  <= s_last_i;
            r_idx   <= '0;
            r_state <= S_DATA;
          end
        end

        S_CRC: begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_idx     <= '0;
            r_crc_out <= r_crc_src;
`ifdef CRC16_CHECK_EN
            r_crc_ok  <= 1'b0;
`endif
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_DATA:  w_bit = r_shift[7];
      S_CRC:   w_bit = r_crc_src[4'd15 - r_idx];
      default: w_bit = 1'b0;
    endcase
  end

  assign bit_o       = w_bit;
  assign bit_valid_o = (r_state == S_DATA) || (r_state == S_CRC);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign crc16_o     = r_crc_out;
`ifdef CRC16_CHECK_EN
  assign crc_ok_o    = r_crc_ok;
`endif

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crc16_frame_ctrl
// Scoreboard bench: the driver pushes the expected serial bits and frame-end
// record (CRC, done cycle, idle-bit count) into queues; an independent monitor
// pops and compares whenever the DUT presents a bit or a done pulse.
// Expected CRCs come from polynomial long division of the augmented message.
// Optional check-mode tests build with CRC16_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_crc16_frame_ctrl;

  typedef logic [7:0] bq_t[$];
  typedef int         iq_t[$];
  typedef struct {
    logic [15:0] crc;
    int          cyc;
    int          waits;
    bit          chk;
    bit          ok;
  } done_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic        bit_o;
  logic        bit_valid_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] crc16_o;
`ifdef CRC16_CHECK_EN
  logic        check_i;
  logic        crc_ok_o;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          sb_on = 1'b1;
  bit          exp_bits[$];
  done_t       exp_done[$];
  logic [15:0] hold_crc = 16'h0000;
  int          wait_cnt = 0;

  crc16_frame_ctrl dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .crc16_o     (crc16_o)
`ifdef CRC16_CHECK_EN
    ,
    .check_i     (check_i),
    .crc_ok_o    (crc_ok_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Remainder of message(x) * x^16 divided by x^16 + 0x1021 (preset 0).
  function automatic logic [15:0] model_crc(input bq_t msg);
    logic [15:0] r;
    logic [7:0]  t;
    logic        top;
    bit          s[$];
    foreach (msg[i]) begin
      t = msg[i];
      for (int b = 7; b >= 0; b--) s.push_back(t[b]);
    end
    repeat (16) s.push_back(1'b0);
    r = 16'h0000;
    foreach (s[k]) begin
      top = r[15];
      r   = {r[14:0], s[k]};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic iq_t zeros(input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(0);
    return q;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    bit    eb;
    done_t ed;
    if (!rstn_i) begin
      hold_crc = 16'h0000;
      wait_cnt = 0;
    end else begin
      if (bit_valid_o) begin
        if (sb_on) begin
          checks++;
          if (exp_bits.size() == 0) begin
            errors++;
            $display("FAIL extra_bit cyc %0d: got bit %b, none expected", cyc, bit_o);
          end else begin
            eb = exp_bits.pop_front();
            if (bit_o !== eb) begin
              errors++;
              $display("FAIL serial_bit cyc %0d: got %b want %b", cyc, bit_o, eb);
            end
          end
        end
      end else begin
        checks++;
        if (bit_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_bit cyc %0d: got %b want 0", cyc, bit_o);
        end
        if (busy_o && !done_o) wait_cnt++;
      end

      if (done_o) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc %0d: got done_o=1 want 0", cyc);
        end else begin
          ed = exp_done.pop_front();
          if (crc16_o !== ed.crc) begin
            errors++;
            $display("FAIL crc16 cyc %0d: got %h want %h", cyc, crc16_o, ed.crc);
          end
          checks++;
          if (cyc != ed.cyc) begin
            errors++;
            $display("FAIL done_cycle: got %0d want %0d", cyc, ed.cyc);
          end
          checks++;
          if (wait_cnt != ed.waits) begin
            errors++;
            $display("FAIL wait_cycles cyc %0d: got %0d want %0d", cyc, wait_cnt, ed.waits);
          end
          checks++;
          if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_done cyc %0d: got %b want 1", cyc, busy_o);
          end
`ifdef CRC16_CHECK_EN
          if (ed.chk) begin
            checks++;
            if (crc_ok_o !== ed.ok) begin
              errors++;
              $display("FAIL crc_ok cyc %0d: got %b want %b", cyc, crc_ok_o, ed.ok);
            end
          end
`endif
          hold_crc = ed.crc;
        end
        wait_cnt = 0;
      end else begin
        checks++;
        if (crc16_o !== hold_crc) begin
          errors++;
          $display("FAIL crc_hold cyc %0d: got %h want %h", cyc, crc16_o, hold_crc);
        end
      end
    end
  end

  task automatic send_frame(input bq_t d, input iq_t gap, input bit chk, input bit push,
                            input int nsend, input logic [15:0] crc_exp, input bit ok_exp,
                            output int n0, output int dcyc);
    int          len;
    int          tot;
    int          to;
    logic [7:0]  t;
    done_t       e;
    len  = d.size();
    tot  = 0;
    n0   = 0;
    dcyc = 0;
    if (push) begin
      foreach (d[i]) begin
        t = d[i];
        for (int b = 7; b >= 0; b--) exp_bits.push_back(t[b]);
      end
      if (!chk) for (int b = 15; b >= 0; b--) exp_bits.push_back(crc_exp[b]);
    end
    for (int i = 0; i < nsend; i++) begin
      to = 0;
      @(negedge clk_i);
      while (!s_ready_o && to < 400) begin
        @(negedge clk_i);
        to++;
      end
      if (to >= 400) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout byte %0d: got s_ready_o=0 for %0d cycles want 1", i, to);
        return;
      end
      repeat (gap[i]) @(negedge clk_i);
      if (i > 0) tot += gap[i];
      s_valid_i = 1'b1;
      s_data_i  = d[i];
      s_last_i  = (i == len - 1);
`ifdef CRC16_CHECK_EN
      check_i   = chk;
`endif
      checks++;
      if (s_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL ready byte %0d: got %b want 1", i, s_ready_o);
      end
      if (i == 0) n0 = cyc;
      @(posedge clk_i);
      #1;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_data_i  = 8'($urandom);
`ifdef CRC16_CHECK_EN
      check_i   = 1'b0;
`endif
    end
    dcyc = n0 + 8 * len + (chk ? 1 : 17) + tot;
    if (push) begin
      e.crc   = crc_exp;
      e.cyc   = dcyc;
      e.waits = tot;
      e.chk   = chk;
      e.ok    = ok_exp;
      exp_done.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bit_o !== 1'b0 || bit_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got bit=%b bv=%b busy=%b done=%b want 0 0 0 0",
               tag, bit_o, bit_valid_o, busy_o, done_o);
    end
    checks++;
    if (crc16_o !== 16'h0000) begin
      errors++;
      $display("FAIL %s_crc: got %h want 0000", tag, crc16_o);
    end
    checks++;
    if (s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", tag, s_ready_o);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || exp_bits.size() != 0) && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d frames %0d bits pending want 0",
               exp_done.size(), exp_bits.size());
    end
  endtask

  initial begin
    bq_t  d;
    iq_t  g;
    int   n0, dc, na, da;
    int   len;

    rstn_i    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
`ifdef CRC16_CHECK_EN
    check_i   = 1'b0;
`endif
    #12;
    check_reset_outputs("por");
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("post_release");

    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(d, zeros(9), 1'b0, 1'b1, 9, 16'h31C3, 1'b0, n0, dc);

    d = '{8'h01};
    send_frame(d, zeros(1), 1'b0, 1'b1, 1, 16'h1021, 1'b0, n0, dc);

    d = '{8'hA5, 8'h5A};
    g = '{0, 3};
    send_frame(d, g, 1'b0, 1'b1, 2, model_crc(d), 1'b0, n0, dc);

    // Back-to-back: second frame must be accepted in the single IDLE cycle.
    d = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(d, zeros(3), 1'b0, 1'b1, 3, model_crc(d), 1'b0, na, da);
    d = '{8'h12, 8'h34};
    send_frame(d, zeros(2), 1'b0, 1'b1, 2, model_crc(d), 1'b0, n0, dc);
    checks++;
    if (n0 != da + 1) begin
      errors++;
      $display("FAIL b2b_accept: got cycle %0d want %0d", n0, da + 1);
    end

    // Reset during byte 2 of a 4-byte frame.
    drain(500);
    sb_on = 1'b0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(d, zeros(4), 1'b0, 1'b0, 2, 16'h0000, 1'b0, n0, dc);
    #3;
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("mid_frame_rst");
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    sb_on  = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("after_rst");
    d = '{8'h01};
    send_frame(d, zeros(1), 1'b0, 1'b1, 1, 16'h1021, 1'b0, n0, dc);

    for (int f = 0; f < 25; f++) begin
      d   = {};
      g   = {};
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        d.push_back(8'($urandom));
        g.push_back(($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0);
      end
      send_frame(d, g, 1'b0, 1'b1, len, model_crc(d), 1'b0, n0, dc);
    end

`ifdef CRC16_CHECK_EN
    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
    send_frame(d, zeros(11), 1'b1, 1'b1, 11, 16'h0000, 1'b1, n0, dc);
    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC2};
    send_frame(d, zeros(11), 1'b1, 1'b1, 11, model_crc(d), 1'b0, n0, dc);
    for (int f = 0; f < 4; f++) begin
      logic [15:0] c;
      d   = {};
      len = $urandom_range(5, 1);
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      c = model_crc(d);
      d.push_back(c[15:8]);
      d.push_back(c[7:0]);
      g = zeros(len + 2);
      g[len] = $urandom_range(2);
      send_frame(d, g, 1'b1, 1'b1, len + 2, 16'h0000, 1'b1, n0, dc);
    end
`endif

    drain(500);
    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc16_frame_ctrl.md
CRC16_FRAME_CTRL -- requirements
Module: crc16_frame_ctrl

Interface
REQ-001 Parameter POLY, default 16'h1021, CRC16 generator polynomial (non-reflected, MSB-first).
REQ-002 Parameter INIT, default 16'h0000, CRC register value loaded at frame start.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 s_data_i  input  8  frame byte.
REQ-006 s_valid_i  input  1  byte valid.
REQ-007 s_last_i  input  1  byte is last of frame; qualified by s_valid_i.
REQ-008 s_ready_o  output  1  controller accepts a byte this cycle.
REQ-009 bit_o  output  1  serial output bit, MSB first.
REQ-010 bit_valid_o  output  1  bit_o carries a frame bit this cycle.
REQ-011 busy_o  output  1  frame in progress (state not IDLE).
REQ-012 done_o  output  1  one-cycle pulse at frame end.
REQ-013 crc16_o  output  16  CRC of frame data bits, held from done_o until next frame's done_o.

Function
REQ-014 FSM states SHALL be IDLE, DATA, WAIT, CRC, DONE.
REQ-015 Byte transfer SHALL occur when s_valid_i && s_ready_o; s_ready_o is high in IDLE, in WAIT, and in DATA at bit index 7 when the current byte is not last.
REQ-016 IDLE, transfer: load INIT into CRC register, load shift register, bit index 0, go DATA.
REQ-017 DATA: bit_valid_o=1, bit_o = shift register MSB, CRC register updated with that bit, bit index increments each cycle.
REQ-018 DATA at bit index 7: not last and transfer -> next byte, DATA (no gap); not last and no transfer -> WAIT; last -> CRC (or DONE in check mode, REQ-027).
REQ-019 WAIT: bit_valid_o=0, CRC register held; transfer -> DATA with bit index 0.
REQ-020 Transition into CRC SHALL latch the final data CRC into crc16_o's source register; CRC state emits those 16 bits MSB first, bit_valid_o=1, 16 cycles, then DONE.
REQ-021 DONE: one cycle, done_o=1, bit_valid_o=0, s_ready_o=0, then IDLE.
REQ-022 Latency: byte accepted in cycle N -> its MSB on bit_o in cycle N+1; frame of L bytes with no gaps -> done_o in cycle N+8L+17.
REQ-023 Bytes are never accepted outside the rules of REQ-015; s_valid_i with s_ready_o low SHALL be held by the source.
REQ-024 bit_o SHALL be 0 whenever bit_valid_o is 0.

Reset
REQ-025 rstn_i low SHALL immediately force IDLE, s_ready_o=1 after release, bit_o=0, bit_valid_o=0, busy_o=0, done_o=0, crc16_o=16'h0000, CRC register=INIT, bit index 0.
REQ-026 Reset mid-frame SHALL abandon the frame without done_o; the next accepted byte starts a fresh frame.

Configuration
REQ-027 With CRC16_CHECK_EN defined: extra ports check_i (input 1, sampled on first byte transfer) and crc_ok_o (output 1, valid with done_o); in check mode the CRC state is skipped, DONE follows the last data bit, and crc_ok_o = (CRC register == 0), i.e. frame including received CRC bytes has zero remainder.
REQ-028 Without CRC16_CHECK_EN: neither port exists; every frame is generate mode.

Structure
REQ-029 Shared package crc16_pkg SHALL hold the state enum, default POLY/INIT constants, and the bit-index width.
REQ-030 Sub-module crc16_serial SHALL hold the 16-bit LFSR (ports clk_i, rstn_i, clr_i, en_i, data_i, crc16_o); the controller drives clr_i/en_i.

Verification
REQ-031 Frame "123456789" (0x31..0x39), no gaps -> data bits then 0x31C3 MSB first; crc16_o=16'h31C3; done_o at cycle N+89.
REQ-032 Single byte 0x01, last -> bit stream 00000001 + 0x1021; crc16_o=16'h1021.
REQ-033 Frame 0xA5, gap of 3 cycles, 0x5A last -> bit_valid_o low exactly 3 cycles in WAIT; CRC equals gapless reference model.
REQ-034 rstn_i low during byte 2 of a 4-byte frame -> outputs at reset values, no done_o; following frame 0x01 -> crc16_o=16'h1021.
REQ-035 (CRC16_CHECK_EN) check_i=1, frame "123456789",0x31,0xC3 -> crc_ok_o=1, no CRC bits emitted; last byte 0xC2 -> crc_ok_o=0.
REQ-036 Back-to-back frames: done_o, one IDLE cycle, next frame accepted; second crc16_o unaffected by first frame.
